// File: rtl/pulse_gen_pkg.sv
// Shared types for the pulse_gen tick generator: state encoding, default
// parameters and a small state decode helper.
package pulse_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } state_e;

    localparam int unsigned WIDTH_DEFAULT = 25;
    localparam int unsigned LIMIT_DEFAULT = 250_000;

    function automatic logic is_active(state_e s);
        return s != ST_IDLE;
    endfunction

endpackage

// File: rtl/pulse_gen_if.sv
// Control and status bundle of pulse_gen. The master drives the control
// strobes and levels; the slave (pulse_gen) returns tick, count and status.
interface pulse_gen_if #(
    parameter int unsigned WIDTH = 25
) ();

    logic             start;
    logic             stop;
    logic             en;
    logic             oneshot;
    logic             load;
    logic [WIDTH-1:0] limit_in;
    logic             pulse_out;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             load_ack;

    modport master (
        output start, stop, en, oneshot, load, limit_in,
        input  pulse_out, count, busy, load_ack
    );

    modport slave (
        input  start, stop, en, oneshot, load, limit_in,
        output pulse_out, count, busy, load_ack
    );

endinterface

// File: rtl/pulse_gen.sv
// Programmable tick generator: one-cycle pulse every limit_q cycles, periodic
// or one-shot, with pause/stop and a shadowed period that commits at a wrap.
module pulse_gen
    import pulse_gen_pkg::*;
#(
    parameter int unsigned WIDTH         = WIDTH_DEFAULT,
    parameter int unsigned DEFAULT_LIMIT = LIMIT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    pulse_gen_if.slave  bus
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic             os_q, os_d;
    logic             pend_q, pend_d;
    logic             pulse_q, pulse_d;
    logic             ack_q, ack_d;
    logic             busy_q;

    logic             running;
    logic             at_end;
    logic             wrap;
    logic             pend_now;
    logic             commit;
    logic             start_ok;
    logic [WIDTH-1:0] last_count;
    logic [WIDTH-1:0] new_limit;
    logic [WIDTH-1:0] start_limit;

    // NOTE: every signal written in an always_comb gets a default first so no latch is inferred.
    always_comb begin : decode
        running     = is_active(state_q);
        last_count  = limit_q - WIDTH'(1);
        at_end      = (limit_q != '0) && (count_q == last_count);
        wrap        = running && bus.en && !bus.stop && !bus.start && at_end;
        pend_now    = pend_q || bus.load;
        new_limit   = bus.load ? bus.limit_in : shadow_q;
        commit      = pend_now && (!running || wrap);
        // In IDLE a pending or same-cycle load commits on this edge, so start
        // must judge the period it is about to run with.
        start_limit = commit ? new_limit : limit_q;
        start_ok    = bus.start && (running || start_limit != '0);
    end

    always_comb begin : fsm_next
        state_d = state_q;
        count_d = count_q;
        os_d    = os_q;
        pulse_d = 1'b0;
        if (bus.stop) begin
            state_d = ST_IDLE;
            count_d = '0;
        end else if (start_ok) begin
            state_d = ST_RUN;
            count_d = '0;
            os_d    = bus.oneshot;
        end else begin
            unique case (state_q)
                ST_RUN:   if (!bus.en) state_d = ST_PAUSE;
                ST_PAUSE: if (bus.en)  state_d = ST_RUN;
                default:  ;
            endcase
            // Counting resumes on the very edge that leaves PAUSE.
            if (running && bus.en) begin
                if (wrap) begin
                    count_d = '0;
                    pulse_d = 1'b1;
                    if (os_q) state_d = ST_IDLE;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end
        end
    end

    always_comb begin : reload_next
        limit_d  = limit_q;
        shadow_d = shadow_q;
        pend_d   = pend_q;
        ack_d    = 1'b0;
        if (commit) begin
            limit_d = new_limit;
            pend_d  = 1'b0;
            ack_d   = 1'b1;
        end else if (bus.load) begin
            shadow_d = bus.limit_in;
            pend_d   = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin : state_count_regs
        if (!rst_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            os_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            os_q    <= os_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : reload_regs
        if (!rst_n) begin
            limit_q  <= WIDTH'(DEFAULT_LIMIT);
            // NOTE: the shadow is a plain register, not a memory, so it is reset to a known value too.
            shadow_q <= WIDTH'(DEFAULT_LIMIT);
            pend_q   <= 1'b0;
        end else begin
            limit_q  <= limit_d;
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : output_regs
        if (!rst_n) begin
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            pulse_q <= pulse_d;
            busy_q  <= is_active(state_d);
            ack_q   <= ack_d;
        end
    end

    assign bus.pulse_out = pulse_q;
    assign bus.count     = count_q;
    assign bus.busy      = busy_q;
    assign bus.load_ack  = ack_q;

endmodule
